// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with
// start/busy/done handshake, optional signed input, overflow saturation and blanking flags.
module bin_to_bcd_seq #(
    parameter int c_BIN_WIDTH  = 16,
    parameter int c_DEC_DIGITS = 5,
    parameter int c_SIGNED     = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [c_BIN_WIDTH-1:0]      i_bin,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [c_DEC_DIGITS*4-1:0]   o_bcd,
    output logic                        o_neg,
    output logic                        o_ovf,
    output logic [c_DEC_DIGITS-1:0]     o_blank
);

    localparam int NB = 4 * c_DEC_DIGITS;
    localparam int CW = $clog2(c_BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [c_BIN_WIDTH-1:0] mag_q, mag_d;
    logic [NB-1:0]          scr_q, scr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sign_q, sign_d;
    logic                   ovf_q, ovf_d;
    logic [NB-1:0]          bcd_q, bcd_d;
    logic                   neg_q, neg_d;
    logic                   ovf_out_q, ovf_out_d;

    logic [c_BIN_WIDTH-1:0] mag_in;
    logic [NB-1:0]          adj;
    logic                   shift_out;
    logic [c_DEC_DIGITS-1:0] blank;
    logic                   zero_above;

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ovf_out_d = ovf_out_q;
        adj       = scr_q;
        shift_out = 1'b0;

        // Negating the most negative value yields 2^(W-1), which is exact as an unsigned W-bit value
        mag_in = i_bin;
        if ((c_SIGNED != 0) && i_bin[c_BIN_WIDTH-1]) begin
            mag_in = ~i_bin + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mag_d   = mag_in;
                    sign_d  = (c_SIGNED != 0) && i_bin[c_BIN_WIDTH-1] && (mag_in != '0);
                    scr_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(c_BIN_WIDTH);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                for (int unsigned k = 0; k < c_DEC_DIGITS; k++) begin
                    if (scr_q[4*k +: 4] > 4'd4) begin
                        adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
                    end
                end
                {shift_out, scr_d, mag_d} = {adj, mag_q, 1'b0};
                ovf_d = ovf_q | shift_out;
                cnt_d = cnt_q - 1'b1;
                // Results are loaded on the edge entering DONE so they are valid alongside o_done
                if (cnt_q == CW'(1)) begin
                    state_d   = S_DONE;
                    bcd_d     = ovf_d ? {c_DEC_DIGITS{4'h9}} : scr_d;
                    ovf_out_d = ovf_d;
                    neg_d     = sign_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            mag_q     <= '0;
            scr_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            scr_q     <= scr_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    // Leading-zero flags follow the registered result; digit 0 is never blanked
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int unsigned i = 0; i < c_DEC_DIGITS - 1; i++) begin
            zero_above = zero_above & (bcd_q[4*(c_DEC_DIGITS-1-i) +: 4] == 4'd0);
            blank[c_DEC_DIGITS-1-i] = zero_above;
        end
    end

    assign o_busy  = (state_q == S_SHIFT);
    assign o_done  = (state_q == S_DONE);
    assign o_bcd   = bcd_q;
    assign o_neg   = neg_q;
    assign o_ovf   = ovf_out_q;
    assign o_blank = blank;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: three configurations, directed vectors,
// expectations queued at start and checked by per-instance monitors on o_done.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_bc;
    logic        a_start, b_start, c_start;
    logic [15:0] a_bin;
    logic [7:0]  b_bin, c_bin;

    logic        a_busy, a_done, a_neg, a_ovf;
    logic [19:0] a_bcd;
    logic [4:0]  a_blank;
    logic        b_busy, b_done, b_neg, b_ovf;
    logic [11:0] b_bcd;
    logic [2:0]  b_blank;
    logic        c_busy, c_done, c_neg, c_ovf;
    logic [7:0]  c_bcd;
    logic [1:0]  c_blank;

    bin_to_bcd_seq dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_start(a_start), .i_bin(a_bin),
        .o_busy(a_busy), .o_done(a_done), .o_bcd(a_bcd), .o_neg(a_neg),
        .o_ovf(a_ovf), .o_blank(a_blank)
    );

    bin_to_bcd_seq #(.c_BIN_WIDTH(8), .c_DEC_DIGITS(3), .c_SIGNED(1)) dut_b (
        .i_clk(clk), .i_rst(rst_bc), .i_start(b_start), .i_bin(b_bin),
        .o_busy(b_busy), .o_done(b_done), .o_bcd(b_bcd), .o_neg(b_neg),
        .o_ovf(b_ovf), .o_blank(b_blank)
    );

    bin_to_bcd_seq #(.c_BIN_WIDTH(8), .c_DEC_DIGITS(2), .c_SIGNED(0)) dut_c (
        .i_clk(clk), .i_rst(rst_bc), .i_start(c_start), .i_bin(c_bin),
        .o_busy(c_busy), .o_done(c_done), .o_bcd(c_bcd), .o_neg(c_neg),
        .o_ovf(c_ovf), .o_blank(c_blank)
    );

    typedef struct {
        logic [19:0] bcd;
        logic        neg;
        logic        ovf;
        logic [4:0]  blank;
    } exp_t;

    exp_t q_a[$], q_b[$], q_c[$];
    exp_t e_a, e_b, e_c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // ---------------- monitor for the default instance ----------------
    int          busy_a = 0;
    int          last_done_a = 0;
    int          b2b_cnt_a = 0;
    bit          b2b_a = 1'b0;
    logic [19:0] last_bcd_a = '0;

    always @(negedge clk) begin
        if (rst_a) begin
            cmp("a_rst_busy", 32'(a_busy), 32'd0);
            cmp("a_rst_done", 32'(a_done), 32'd0);
            cmp("a_rst_bcd", 32'(a_bcd), 32'd0);
            cmp("a_rst_flags", 32'({a_neg, a_ovf}), 32'd0);
            cmp("a_rst_blank", 32'(a_blank), 32'b11110);
            busy_a     = 0;
            last_bcd_a = '0;
            b2b_cnt_a  = 0;
        end else begin
            if (a_busy) busy_a++;
            if (a_done) begin
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_done: got o_done=1 with bcd=%0h expected no pending request", a_bcd);
                end else begin
                    e_a = q_a.pop_front();
                    cmp("a_bcd", 32'(a_bcd), 32'(e_a.bcd));
                    cmp("a_neg", 32'(a_neg), 32'(e_a.neg));
                    cmp("a_ovf", 32'(a_ovf), 32'(e_a.ovf));
                    cmp("a_blank", 32'(a_blank), 32'(e_a.blank));
                    cmp("a_busy_cycles", 32'(busy_a), 32'd16);
                end
                if (b2b_a) begin
                    if (b2b_cnt_a > 0) cmp("a_b2b_period", 32'(cyc - last_done_a), 32'd18);
                    b2b_cnt_a++;
                end else begin
                    b2b_cnt_a = 0;
                end
                last_done_a = cyc;
                busy_a      = 0;
                last_bcd_a  = a_bcd;
            end else begin
                cmp("a_hold_bcd", 32'(a_bcd), 32'(last_bcd_a));
            end
        end
    end

    // ---------------- monitor for the two 8-bit instances ----------------
    int busy_b = 0;
    int busy_c = 0;

    always @(negedge clk) begin
        if (rst_bc) begin
            cmp("b_rst_bcd", 32'(b_bcd), 32'd0);
            cmp("b_rst_blank", 32'(b_blank), 32'b110);
            cmp("b_rst_ctl", 32'({b_busy, b_done, b_neg, b_ovf}), 32'd0);
            cmp("c_rst_bcd", 32'(c_bcd), 32'd0);
            cmp("c_rst_blank", 32'(c_blank), 32'b10);
            cmp("c_rst_ctl", 32'({c_busy, c_done, c_neg, c_ovf}), 32'd0);
            busy_b = 0;
            busy_c = 0;
        end else begin
            if (b_busy) busy_b++;
            if (c_busy) busy_c++;
            if (b_done) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_done: got o_done=1 with bcd=%0h expected no pending request", b_bcd);
                end else begin
                    e_b = q_b.pop_front();
                    cmp("b_bcd", 32'(b_bcd), 32'(e_b.bcd));
                    cmp("b_neg", 32'(b_neg), 32'(e_b.neg));
                    cmp("b_ovf", 32'(b_ovf), 32'(e_b.ovf));
                    cmp("b_blank", 32'(b_blank), 32'(e_b.blank));
                    cmp("b_busy_cycles", 32'(busy_b), 32'd8);
                end
                busy_b = 0;
            end
            if (c_done) begin
                if (q_c.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL c_unexpected_done: got o_done=1 with bcd=%0h expected no pending request", c_bcd);
                end else begin
                    e_c = q_c.pop_front();
                    cmp("c_bcd", 32'(c_bcd), 32'(e_c.bcd));
                    cmp("c_neg", 32'(c_neg), 32'(e_c.neg));
                    cmp("c_ovf", 32'(c_ovf), 32'(e_c.ovf));
                    cmp("c_blank", 32'(c_blank), 32'(e_c.blank));
                    cmp("c_busy_cycles", 32'(busy_c), 32'd8);
                end
                busy_c = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(input int which);
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            case (which)
                0:       seen = a_done;
                1:       seen = b_done;
                default: seen = c_done;
            endcase
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no o_done on instance %0d expected one within 60 cycles", which);
        end
    endtask

    task automatic pulse_a(input logic [15:0] v);
        @(posedge clk); #1;
        a_start = 1'b1;
        a_bin   = v;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic run_a(input logic [15:0] v, input logic [19:0] bcd, input logic [4:0] blank);
        q_a.push_back('{bcd: bcd, neg: 1'b0, ovf: 1'b0, blank: blank});
        pulse_a(v);
        wait_done(0);
    endtask

    task automatic run_b(input logic [7:0] v, input logic [11:0] bcd, input logic neg, input logic [2:0] blank);
        q_b.push_back('{bcd: 20'(bcd), neg: neg, ovf: 1'b0, blank: 5'(blank)});
        @(posedge clk); #1;
        b_start = 1'b1;
        b_bin   = v;
        @(posedge clk); #1;
        b_start = 1'b0;
        wait_done(1);
    endtask

    task automatic run_c(input logic [7:0] v, input logic [7:0] bcd, input logic ovf, input logic [1:0] blank);
        q_c.push_back('{bcd: 20'(bcd), neg: 1'b0, ovf: ovf, blank: 5'(blank)});
        @(posedge clk); #1;
        c_start = 1'b1;
        c_bin   = v;
        @(posedge clk); #1;
        c_start = 1'b0;
        wait_done(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a   = 1'b1;
        rst_bc  = 1'b1;
        a_start = 1'b0;
        b_start = 1'b0;
        c_start = 1'b0;
        a_bin   = '0;
        b_bin   = '0;
        c_bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_a  = 1'b0;
        rst_bc = 1'b0;

        run_a(16'd65535, 20'h65535, 5'b00000);
        run_a(16'd0,     20'h00000, 5'b11110);
        run_a(16'd42,    20'h00042, 5'b11100);
        run_a(16'd10000, 20'h10000, 5'b00000);

        // second start during busy cycle 5 must be ignored
        q_a.push_back('{bcd: 20'h01234, neg: 1'b0, ovf: 1'b0, blank: 5'b10000});
        pulse_a(16'd1234);
        repeat (4) @(posedge clk);
        #1;
        a_start = 1'b1;
        a_bin   = 16'd9999;
        @(posedge clk); #1;
        a_start = 1'b0;
        wait_done(0);
        repeat (25) @(posedge clk);

        // reset at busy cycle 8 aborts without o_done
        pulse_a(16'd4321);
        repeat (7) @(posedge clk);
        #3;
        rst_a = 1'b1;
        #1;
        cmp("a_abort_busy", 32'(a_busy), 32'd0);
        cmp("a_abort_bcd", 32'(a_bcd), 32'd0);
        cmp("a_abort_blank", 32'(a_blank), 32'b11110);
        repeat (2) @(posedge clk);
        #2;
        rst_a = 1'b0;
        repeat (30) @(posedge clk);
        run_a(16'd9999, 20'h09999, 5'b10000);

        // i_start held high: back-to-back conversions every 18 cycles
        b2b_a = 1'b1;
        repeat (3) q_a.push_back('{bcd: 20'h00500, neg: 1'b0, ovf: 1'b0, blank: 5'b11000});
        @(posedge clk); #1;
        a_start = 1'b1;
        a_bin   = 16'd500;
        wait_done(0);
        wait_done(0);
        wait_done(0);
        @(posedge clk); #1;
        a_start = 1'b0;
        b2b_a   = 1'b0;

        run_b(8'h80, 12'h128, 1'b1, 3'b000);
        run_b(8'hFF, 12'h001, 1'b1, 3'b110);
        run_b(8'h7F, 12'h127, 1'b0, 3'b000);
        run_b(8'h00, 12'h000, 1'b0, 3'b110);
        run_b(8'h9C, 12'h100, 1'b1, 3'b000);

        run_c(8'd255, 8'h99, 1'b1, 2'b00);
        run_c(8'd99,  8'h99, 1'b0, 2'b00);
        run_c(8'd100, 8'h99, 1'b1, 2'b00);
        run_c(8'd5,   8'h05, 1'b0, 2'b10);
        run_c(8'd0,   8'h00, 1'b0, 2'b10);

        repeat (5) @(posedge clk);
        cmp("queues_drained", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Replaces the combinational converter on display paths where wide inputs would make a single-cycle loop too slow or too large.
- Adds a start/busy/done handshake, optional signed (two's-complement) input, digit-overflow saturation and leading-zero blanking flags for the seven-segment driver.

Parameters:
c_BIN_WIDTH, 16, input binary width in bits (legal: 2 to 32)
c_DEC_DIGITS, 5, number of BCD output digits (legal: 1 to 10)
c_SIGNED, 0, 1 = i_bin is two's complement and the magnitude is converted; 0 = i_bin is unsigned

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst  input  1  asynchronous, active-high reset
i_start  input  1  request conversion of i_bin; sampled only in IDLE
i_bin  input  c_BIN_WIDTH  binary value; captured on the accepted i_start edge
o_busy  output  1  high while the conversion is in progress (SHIFT state)
o_done  output  1  one-cycle pulse; result outputs update in the same cycle
o_bcd  output  c_DEC_DIGITS*4  packed BCD result; digit k at bits [4k+3:4k], digit 0 least significant
o_neg  output  1  result is negative (c_SIGNED=1 and input < 0 only)
o_ovf  output  1  magnitude exceeded 10^c_DEC_DIGITS-1
o_blank  output  c_DEC_DIGITS  bit k high = digit k is a leading zero

Behaviour:
- Reset is asynchronous, active-high and one clock domain only (i_clk, i_rst). On reset:
  - FSM goes to IDLE.
  - o_busy, o_done, o_neg and o_ovf are 0; o_bcd is 0.
  - o_blank has all bits 1 except bit 0, which is 0.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - On i_start=1: capture the magnitude into the shift register.
  - Magnitude is the two's-complement negation of i_bin if c_SIGNED=1 and i_bin MSB=1; otherwise it is i_bin.
  - The magnitude of the most negative value, 2^(c_BIN_WIDTH-1), fits in c_BIN_WIDTH unsigned bits and must not wrap.
  - Latch the sign, clear the BCD scratch and the sticky overflow, load the bit counter with c_BIN_WIDTH, then go to SHIFT.
- SHIFT:
  - o_busy=1.
  - Each cycle, first add 3 to every scratch digit greater than 4, then shift {scratch, magnitude} left by 1.
  - If the bit shifted out of the top digit is 1, set sticky overflow.
  - Decrement the counter; after exactly c_BIN_WIDTH SHIFT cycles, go to DONE.
- DONE (one cycle):
  - o_done=1 and o_busy=0.
  - o_bcd is loaded with the scratch value, or with all digits 9 if overflow is set.
  - o_ovf is loaded with the overflow flag.
  - o_neg is loaded with the latched sign AND (magnitude != 0).
  - o_blank is recomputed, then the FSM returns to IDLE.
- Blanking: o_blank[k] = 1 if digit k and all higher digits of the loaded o_bcd are 0, for k >= 1. o_blank[0] is always 0.
- Latency: with the accepted start at edge 0, o_busy is high for edges 1..c_BIN_WIDTH and o_done pulses in cycle c_BIN_WIDTH+1. Throughput is one conversion per c_BIN_WIDTH+2 cycles.
- Result outputs hold their previous values from start through busy, and change only in the o_done cycle.
- i_start is ignored in SHIFT and DONE; it is not queued. i_bin changes after capture have no effect.
- i_start held high continuously gives back-to-back conversions: a new start is accepted in the IDLE cycle right after DONE.
- Reset asserted mid-conversion aborts immediately to the reset values. No o_done is produced for the aborted request.
- Arithmetic: each digit correction is 4-bit and never carries between digits, because digits greater than 4 become at most 12 before the shift.

Test Plan:
- Defaults, i_bin=16'd65535, start pulse -> o_busy high 16 cycles; o_done in cycle 17; o_bcd=20'h65535, o_ovf=0, o_blank=5'b00000.
- Defaults, i_bin=0 -> o_bcd=0, o_blank=5'b11110, o_neg=0. Then i_bin=16'd42 -> o_bcd=20'h00042, o_blank=5'b11100.
- c_BIN_WIDTH=8, c_DEC_DIGITS=3, c_SIGNED=1, i_bin=8'h80 -> o_bcd=12'h128, o_neg=1. Then i_bin=8'hFF -> o_bcd=12'h001, o_neg=1. Then i_bin=8'h7F -> o_bcd=12'h127, o_neg=0.
- c_BIN_WIDTH=8, c_DEC_DIGITS=2, unsigned, i_bin=8'd255 -> o_ovf=1, o_bcd=8'h99. Then i_bin=8'd99 -> o_ovf=0, o_bcd=8'h99.
- Defaults, start with i_bin=1234; pulse i_start again with i_bin=9999 at busy cycle 5 -> single o_done, o_bcd=20'h01234; second start ignored.
- Defaults, assert i_rst at busy cycle 8 -> outputs return to reset values at once, no o_done pulse. After release, a new start converts correctly. Also hold i_start high -> o_done every 18 cycles.
